// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, decode constants and decoded bundle type
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_XOR  = 3'b001,
      ALU_SLL  = 3'b010,
      ALU_ADD  = 3'b011,
      ALU_SUB  = 3'b100,
      ALU_MUL  = 3'b101,
      ALU_ADDI = 3'b110,
      ALU_SRAI = 3'b111
   } alu_op_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      alu_op_e     alu_ctrl;
      logic        use_imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } dec_bundle_t;

endpackage

// File: rtl/alu_ctrl_lut.sv
// rtl/alu_ctrl_lut.sv - combinational instruction to ALU control bundle decode
module alu_ctrl_lut
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] inst_i,
   output dec_bundle_t bundle_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];

   always_comb begin
      bundle_o           = '0;
      bundle_o.imm       = {{20{inst_i[31]}}, inst_i[31:20]};
      bundle_o.rs1       = inst_i[19:15];
      bundle_o.rs2       = inst_i[24:20];
      bundle_o.rd        = inst_i[11:7];
      bundle_o.alu_ctrl  = ALU_ADD;
      bundle_o.use_imm   = 1'b0;
      bundle_o.illegal   = 1'b1;
      bundle_o.reg_write = 1'b0;

      case (opcode)
         OP_R: begin
            if (funct7 == F7_BASE) begin
               bundle_o.illegal = 1'b0;
               case (funct3)
                  3'b000:  bundle_o.alu_ctrl = ALU_ADD;
                  3'b111:  bundle_o.alu_ctrl = ALU_AND;
                  3'b100:  bundle_o.alu_ctrl = ALU_XOR;
                  3'b001:  bundle_o.alu_ctrl = ALU_SLL;
                  default: bundle_o.illegal  = 1'b1;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               bundle_o.illegal  = 1'b0;
               bundle_o.alu_ctrl = ALU_SUB;
            end else if (funct7 == F7_MULDIV && funct3 == 3'b000) begin
               bundle_o.illegal  = 1'b0;
               bundle_o.alu_ctrl = ALU_MUL;
            end
         end
         OP_I: begin
            if (funct3 == 3'b000) begin
               bundle_o.illegal  = 1'b0;
               bundle_o.alu_ctrl = ALU_ADDI;
               bundle_o.use_imm  = 1'b1;
            end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
               bundle_o.illegal  = 1'b0;
               bundle_o.alu_ctrl = ALU_SRAI;
               bundle_o.use_imm  = 1'b1;
            end
         end
         default: ;
      endcase

      // Unsupported encodings fall back to a harmless ADD with no writeback
      if (bundle_o.illegal) begin
         bundle_o.alu_ctrl = ALU_ADD;
         bundle_o.use_imm  = 1'b0;
      end else begin
         bundle_o.reg_write = 1'b1;
      end
   end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - registered decode stage with skid buffer and illegal counter
module alu_ctrl_decoder
   import alu_ctrl_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [31:0]      inst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [2:0]       alu_ctrl_o,
   output logic             use_imm_o,
   output logic [31:0]      imm_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [4:0]       rd_o,
   output logic             reg_write_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   dec_bundle_t      dec;
   dec_bundle_t      out_q;
   dec_bundle_t      skid_q;
   logic             out_valid_q;
   logic             skid_valid_q;
   logic             in_ready_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             out_free;

   alu_ctrl_lut u_lut (
      .inst_i   (inst_i),
      .bundle_o (dec)
   );

   assign accept   = in_valid_i & in_ready_q;
   // Output slot can take a new bundle when empty or being consumed this edge
   assign out_free = ~out_valid_q | out_ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         if (out_free) begin
            if (skid_valid_q) begin
               out_q        <= skid_q;
               out_valid_q  <= 1'b1;
               skid_valid_q <= 1'b0;
               in_ready_q   <= 1'b1;
            end else if (accept) begin
               out_q       <= dec;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
         end

         if (accept && dec.illegal && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign alu_ctrl_o    = out_q.alu_ctrl;
   assign use_imm_o     = out_q.use_imm;
   assign imm_o         = out_q.imm;
   assign rs1_o         = out_q.rs1;
   assign rs2_o         = out_q.rs2;
   assign rd_o          = out_q.rd;
   assign reg_write_o   = out_q.reg_write;
   assign illegal_o     = out_q.illegal;
   assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - scoreboard bench for alu_ctrl_decoder
module tb_alu_ctrl_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  alu_ctrl;
   logic        use_imm;
   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic        reg_write;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_popped = 0;
   int exp_cnt  = 0;
   int cyc      = 0;
   int last_pop = 0;
   int prev_pop = 0;
   bit drv_done;

   logic [52:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_ctrl_decoder #(.CNT_W(8)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .inst_i        (inst),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .alu_ctrl_o    (alu_ctrl),
      .use_imm_o     (use_imm),
      .imm_o         (imm),
      .rs1_o         (rs1),
      .rs2_o         (rs2),
      .rd_o          (rd),
      .reg_write_o   (reg_write),
      .illegal_o     (illegal),
      .illegal_cnt_o (illegal_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Packed as {alu_ctrl, use_imm, imm, rs1, rs2, rd, reg_write, illegal}
   function automatic logic [52:0] model(input logic [31:0] i);
      logic [2:0]  op;
      logic        ui;
      logic        ill;
      logic [16:0] key;
      op  = 3'b011;
      ui  = 1'b0;
      ill = 1'b0;
      key = {i[31:25], i[14:12], i[6:0]};
      casez (key)
         17'b0000000_000_0110011: op = 3'b011;
         17'b0000000_111_0110011: op = 3'b000;
         17'b0000000_100_0110011: op = 3'b001;
         17'b0000000_001_0110011: op = 3'b010;
         17'b0100000_000_0110011: op = 3'b100;
         17'b0000001_000_0110011: op = 3'b101;
         17'b???????_000_0010011: begin op = 3'b110; ui = 1'b1; end
         17'b0100000_101_0010011: begin op = 3'b111; ui = 1'b1; end
         default: ill = 1'b1;
      endcase
      return {op, ui, {{20{i[31]}}, i[31:20]}, i[19:15], i[24:20], i[11:7], ~ill, ill};
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", {63'd0, out_valid}, 64'd0);
         end else begin
            check("bundle", {11'd0, alu_ctrl, use_imm, imm, rs1, rs2, rd, reg_write, illegal},
                  {11'd0, sb.pop_front()});
            n_popped++;
            prev_pop = last_pop;
            last_pop = cyc;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic push(input logic [31:0] ins);
      int t = 0;
      logic [52:0] e;
      in_valid = 1'b1;
      inst     = ins;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", {63'd0, in_ready}, 64'd1);
      end else begin
         e = model(ins);
         sb.push_back(e);
         n_pushed++;
         if (e[0] && exp_cnt < 255) exp_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] a, b, c;
      logic [11:0] im;
      a  = 5'($urandom);
      b  = 5'($urandom);
      c  = 5'($urandom);
      im = 12'($urandom);
      case ($urandom_range(0, 8))
         0: return {7'b0000000, b, a, 3'b000, c, 7'b0110011};
         1: return {7'b0000000, b, a, 3'b111, c, 7'b0110011};
         2: return {7'b0000000, b, a, 3'b100, c, 7'b0110011};
         3: return {7'b0000000, b, a, 3'b001, c, 7'b0110011};
         4: return {7'b0100000, b, a, 3'b000, c, 7'b0110011};
         5: return {7'b0000001, b, a, 3'b000, c, 7'b0110011};
         6: return {im, a, 3'b000, c, 7'b0010011};
         7: return {7'b0100000, b, a, 3'b101, c, 7'b0010011};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_cnt", {56'd0, illegal_cnt}, 64'd0);
      check("rst_bundle", {11'd0, alu_ctrl, use_imm, imm, rs1, rs2, rd, reg_write, illegal}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add, then latency of exactly one cycle
      push(32'h002081B3);
      check("lat_valid", {63'd0, out_valid}, 64'd1);
      check("add_ctrl", {61'd0, alu_ctrl}, 64'd3);
      check("add_rd", {59'd0, rd}, 64'd3);
      drain();

      // sub then mul back to back
      push(32'h407302B3);
      push(32'h023100B3);
      drain();
      check("no_bubble", 64'(last_pop - prev_pop), 64'd1);

      push(32'hFFF00093);
      push(32'h40315113);
      drain();

      // Illegal encodings and counter steps
      push(32'h00000000);
      drain();
      check("cnt_1", {56'd0, illegal_cnt}, 64'd1);
      push(32'h0000707F);
      drain();
      check("cnt_2", {56'd0, illegal_cnt}, 64'd2);

      // Stall with three instructions
      out_ready = 1'b0;
      push(32'h002081B3);
      push(32'h407302B3);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      drv_done = 1'b0;
      fork
         begin
            push(32'h023100B3);
            drv_done = 1'b1;
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("stall_hold_ready", {63'd0, in_ready}, 64'd0);
      check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      check("stall_hold_ctrl", {61'd0, alu_ctrl}, 64'd3);
      out_ready = 1'b1;
      for (int t = 0; t < 50 && !drv_done; t++) @(posedge clk);
      #1;
      check("stall_drv_done", {63'd0, drv_done}, 64'd1);
      drain();

      // Random traffic with random back-pressure
      drv_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 60; k++) push(rand_inst());
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("rand_cnt", {56'd0, illegal_cnt}, 64'(exp_cnt));

      // Saturation
      for (int k = 0; k < 300; k++) push(32'h0000707F);
      drain();
      check("sat_cnt", {56'd0, illegal_cnt}, 64'd255);
      check("sat_model", 64'(exp_cnt), 64'd255);

      // Reset mid-stall with skid full
      out_ready = 1'b0;
      push(32'h00000000);
      push(32'h002081B3);
      check("skid_full_ready", {63'd0, in_ready}, 64'd0);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_cnt", {56'd0, illegal_cnt}, 64'd0);
      check("mid_rst_bundle", {11'd0, alu_ctrl, use_imm, imm, rs1, rs2, rd, reg_write, illegal}, 64'd0);
      n_pushed = n_pushed - sb.size();
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", {63'd0, in_ready}, 64'd1);
      check("post_rst_valid", {63'd0, out_valid}, 64'd0);
      push(32'h023100B3);
      drain();
      check("pop_count", 64'(n_popped), 64'(n_pushed));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
